// File: rtl/fetch_unit.sv
// fetch_unit: 6502-style instruction fetch and addressing-mode resolver.
// Reads the opcode and its operand/pointer bytes from a byte-wide memory,
// resolves the effective address and presents the finished instruction to
// the execute stage through a valid/accept handshake.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0600,
    parameter bit                    ZP_WRAP    = 1'b1
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_data,
    input  logic [REG_WIDTH-1:0]  x_reg,
    input  logic [REG_WIDTH-1:0]  y_reg,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid,
    input  logic                  instr_accept,
    output logic [REG_WIDTH-1:0]  opcode,
    output logic [REG_WIDTH-1:0]  imm,
    output logic [ADDR_WIDTH-1:0] eff_addr,
    output logic [3:0]            am_out,
    output logic                  page_cross
);

    typedef enum logic [2:0] {
        S_OPC,
        S_OP1,
        S_OP2,
        S_PLO,
        S_PHI,
        S_HOLD
    } state_e;

    typedef enum logic [3:0] {
        AM_IMPL  = 4'd0,
        AM_IMM   = 4'd1,
        AM_ZPG   = 4'd2,
        AM_ZPG_X = 4'd3,
        AM_ZPG_Y = 4'd4,
        AM_ABS   = 4'd5,
        AM_ABS_X = 4'd6,
        AM_ABS_Y = 4'd7,
        AM_X_IND = 4'd8,
        AM_IND_Y = 4'd9,
        AM_REL   = 4'd10
    } am_e;

    // Map an opcode to its addressing mode using the bbb/cc fields.
    function automatic am_e decode(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] cc;
        am_e        am;
        bbb = op[4:2];
        cc  = op[1:0];
        am  = AM_IMPL;
        case (bbb)
            3'd0: begin
                if (cc == 2'b01)       am = AM_X_IND;
                else if (op == 8'h20)  am = AM_ABS;
                else if (op[7])        am = AM_IMM;
                else                   am = AM_IMPL;
            end
            3'd1: am = AM_ZPG;
            3'd2: am = (cc == 2'b01) ? AM_IMM : AM_IMPL;
            3'd3: am = AM_ABS;
            3'd4: begin
                if (cc == 2'b01)       am = AM_IND_Y;
                else if (cc == 2'b00)  am = AM_REL;
                else                   am = AM_IMPL;
            end
            3'd5: am = (cc == 2'b10 && op[7:6] == 2'b10) ? AM_ZPG_Y : AM_ZPG_X;
            3'd6: am = (cc == 2'b01) ? AM_ABS_Y : AM_IMPL;
            default: am = (op == 8'hBE) ? AM_ABS_Y : AM_ABS_X;
        endcase
        return am;
    endfunction

    // Zero-page sum: stays inside page zero when ZP_WRAP is set.
    function automatic logic [ADDR_WIDTH-1:0] zp_sum(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH-1:0] s;
        s = a + b;
        if (ZP_WRAP) begin
            s = {{(ADDR_WIDTH-8){1'b0}}, s[7:0]};
        end
        return s;
    endfunction

    // Carry out of the low byte when an index register is added to it.
    function automatic logic low_carry(input logic [REG_WIDTH-1:0] a,
                                       input logic [REG_WIDTH-1:0] b);
        logic [REG_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[REG_WIDTH];
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  opc_q, opc_d;
    am_e                   am_q, am_d;
    logic [REG_WIDTH-1:0]  op1_q, op1_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]  lo_q, lo_d;
    logic [REG_WIDTH-1:0]  opcode_q, opcode_d;
    logic [REG_WIDTH-1:0]  imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] eff_q, eff_d;
    am_e                   amo_q, amo_d;
    logic                  pcx_q, pcx_d;

    am_e                   dec_am;
    logic [REG_WIDTH-1:0]  idx;
    logic [REG_WIDTH-1:0]  ptr_off;

    assign dec_am = decode(mem_data[7:0]);

    // Select the index register added to the final address, and the one added to the zero-page pointer.
    always_comb begin
        idx     = '0;
        ptr_off = '0;
        case (am_q)
            AM_ZPG_X, AM_ABS_X:           idx = x_reg;
            AM_ZPG_Y, AM_ABS_Y, AM_IND_Y: idx = y_reg;
            default:                      idx = '0;
        endcase
        if (am_q == AM_X_IND) begin
            ptr_off = x_reg;
        end
    end

    // Fetch sequencer: captures each byte on the edge after its read and finalizes outputs on entry to HOLD.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opc_d    = opc_q;
        am_d     = am_q;
        op1_d    = op1_q;
        ptr_d    = ptr_q;
        lo_d     = lo_q;
        opcode_d = opcode_q;
        imm_d    = imm_q;
        eff_d    = eff_q;
        amo_d    = amo_q;
        pcx_d    = pcx_q;
        if (pc_load) begin
            state_d = S_OPC;
            pc_d    = pc_load_val;
        end else begin
            case (state_q)
                S_OPC: begin
                    pc_d  = pc_q + ADDR_WIDTH'(1);
                    opc_d = mem_data;
                    am_d  = dec_am;
                    if (dec_am == AM_IMPL) begin
                        opcode_d = mem_data;
                        imm_d    = '0;
                        eff_d    = '0;
                        amo_d    = AM_IMPL;
                        pcx_d    = 1'b0;
                        state_d  = S_HOLD;
                    end else begin
                        state_d  = S_OP1;
                    end
                end
                S_OP1: begin
                    pc_d  = pc_q + ADDR_WIDTH'(1);
                    op1_d = mem_data;
                    case (am_q)
                        AM_IMM, AM_REL, AM_ZPG, AM_ZPG_X, AM_ZPG_Y: begin
                            opcode_d = opc_q;
                            amo_d    = am_q;
                            pcx_d    = 1'b0;
                            imm_d    = '0;
                            eff_d    = '0;
                            if (am_q == AM_IMM || am_q == AM_REL) begin
                                imm_d = mem_data;
                            end else if (am_q == AM_ZPG) begin
                                eff_d = ADDR_WIDTH'(mem_data);
                            end else begin
                                eff_d = zp_sum(ADDR_WIDTH'(mem_data), ADDR_WIDTH'(idx));
                            end
                            state_d = S_HOLD;
                        end
                        AM_X_IND, AM_IND_Y: begin
                            ptr_d   = zp_sum(ADDR_WIDTH'(mem_data), ADDR_WIDTH'(ptr_off));
                            state_d = S_PLO;
                        end
                        default: state_d = S_OP2;
                    endcase
                end
                S_OP2: begin
                    pc_d     = pc_q + ADDR_WIDTH'(1);
                    opcode_d = opc_q;
                    amo_d    = am_q;
                    imm_d    = '0;
                    eff_d    = ADDR_WIDTH'({mem_data, op1_q}) + ADDR_WIDTH'(idx);
                    pcx_d    = low_carry(op1_q, idx);
                    state_d  = S_HOLD;
                end
                S_PLO: begin
                    lo_d    = mem_data;
                    state_d = S_PHI;
                end
                S_PHI: begin
                    opcode_d = opc_q;
                    amo_d    = am_q;
                    imm_d    = '0;
                    eff_d    = ADDR_WIDTH'({mem_data, lo_q}) + ADDR_WIDTH'(idx);
                    pcx_d    = low_carry(lo_q, idx);
                    state_d  = S_HOLD;
                end
                S_HOLD: begin
                    if (instr_accept) begin
                        state_d = S_OPC;
                    end
                end
                default: state_d = S_OPC;
            endcase
        end
    end

    // State and datapath registers; reset discards any partially fetched instruction.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_OPC;
            pc_q     <= RESET_PC;
            opc_q    <= '0;
            am_q     <= AM_IMPL;
            op1_q    <= '0;
            ptr_q    <= '0;
            lo_q     <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            eff_q    <= '0;
            amo_q    <= AM_IMPL;
            pcx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opc_q    <= opc_d;
            am_q     <= am_d;
            op1_q    <= op1_d;
            ptr_q    <= ptr_d;
            lo_q     <= lo_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            eff_q    <= eff_d;
            amo_q    <= amo_d;
            pcx_q    <= pcx_d;
        end
    end

    // Read address: PC for opcode/operands, the zero-page pointer pair for indirect modes.
    always_comb begin
        mem_addr = pc_q;
        case (state_q)
            S_PLO:   mem_addr = ptr_q;
            S_PHI:   mem_addr = zp_sum(ptr_q, ADDR_WIDTH'(1));
            default: mem_addr = pc_q;
        endcase
    end

    assign mem_rd      = reset_n & (state_q != S_HOLD);
    assign pc          = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign opcode      = opcode_q;
    assign imm         = imm_q;
    assign eff_addr    = eff_q;
    assign am_out      = amo_q;
    assign page_cross  = pcx_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address/PC width.
REQ-002 SHALL have parameter REG_WIDTH, default 8, data/opcode width.
REQ-003 SHALL have parameter RESET_PC, default 16'h0600, PC value after reset.
REQ-004 SHALL have parameter ZP_WRAP, default 1; 1 = zero-page index/pointer sums wrap mod 256, 0 = full-width sum.
REQ-005 phi1  in  1  sole clock; all state updates on posedge phi1.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 mem_addr  out  ADDR_WIDTH  read address.
REQ-008 mem_rd  out  1  read strobe; mem_data valid at the following posedge.
REQ-009 mem_data  in  REG_WIDTH  read data.
REQ-010 x_reg, y_reg  in  REG_WIDTH each  index registers, sampled when added.
REQ-011 pc_load  in  1  redirect request; pc_load_val  in  ADDR_WIDTH  target.
REQ-012 pc  out  ADDR_WIDTH  current fetch PC.
REQ-013 instr_valid  out  1; instr_accept  in  1  handshake to execute.
REQ-014 opcode, imm  out  REG_WIDTH; eff_addr  out  ADDR_WIDTH; am_out  out  4; page_cross  out  1.

Function
REQ-015 States SHALL be OPC (read opcode at pc), OP1, OP2 (operand bytes at pc), PLO, PHI (pointer bytes), HOLD (instr_valid=1).
REQ-016 Each state except HOLD SHALL drive mem_rd=1 for one cycle and capture mem_data at the next edge; pc SHALL increment by 1 after OPC/OP1/OP2 reads only.
REQ-017 am_out codes SHALL be IMPL 0, IMM 1, ZPG 2, ZPG_X 3, ZPG_Y 4, ABS 5, ABS_X 6, ABS_Y 7, X_IND 8, IND_Y 9, REL 10.
REQ-018 Decode from bbb=opcode[4:2], cc=opcode[1:0]: bbb000: cc01 X_IND; 8'h20 ABS; opcode[7]=1 and cc!=01 IMM; else IMPL.
REQ-019 bbb001 ZPG; bbb010: cc01 IMM, else IMPL; bbb011 ABS; bbb100: cc01 IND_Y, cc00 REL, else IMPL.
REQ-020 bbb101: cc10 with opcode[7:6]=10 ZPG_Y, else ZPG_X; bbb110: cc01 ABS_Y, else IMPL; bbb111: 8'hBE ABS_Y, else ABS_X.
REQ-021 Paths: IMPL OPC->HOLD; IMM/REL/ZPG/ZPG_X/ZPG_Y OPC->OP1->HOLD; ABS* OPC->OP1->OP2->HOLD; X_IND/IND_Y OPC->OP1->PLO->PHI->HOLD.
REQ-022 Latency from entering OPC to instr_valid=1 SHALL be 1/2/3/4 cycles for IMPL / 1-operand / ABS* / indirect.
REQ-023 imm SHALL hold operand byte 1 (IMM, REL); eff_addr SHALL be zero for IMPL, IMM, REL.
REQ-024 ZPG: eff_addr={0,op}; ZPG_X/ZPG_Y: op+X/Y, truncated to 8 bits when ZP_WRAP=1.
REQ-025 ABS: {op2,op1}; ABS_X/ABS_Y: {op2,op1}+X/Y mod 2^ADDR_WIDTH; page_cross = carry out of low byte.
REQ-026 X_IND: ptr=op+X; reads ptr, ptr+1 (both mod 256 when ZP_WRAP=1); eff_addr={hi,lo}; page_cross=0.
REQ-027 IND_Y: reads op, op+1 (same wrap rule); eff_addr={hi,lo}+Y mod 2^ADDR_WIDTH; page_cross = low-byte carry.
REQ-028 In HOLD all instruction outputs SHALL be stable; on instr_accept=1 SHALL clear instr_valid and enter OPC at that edge.
REQ-029 instr_accept while instr_valid=0 SHALL be ignored.
REQ-030 pc_load=1 SHALL, at that edge from any state, abort the fetch, set pc=pc_load_val, clear instr_valid, enter OPC; wins over simultaneous instr_accept.
REQ-031 pc SHALL wrap from all-ones to 0.

Reset
REQ-032 reset_n=0 SHALL immediately force pc=RESET_PC, state OPC, mem_rd=0, instr_valid=0, opcode/imm/eff_addr/am_out/page_cross=0, independent of phi1.
REQ-033 mem_rd SHALL be gated to 0 while reset_n=0; first read at pc=RESET_PC in the first cycle after release.
REQ-034 Reset asserted mid-fetch SHALL discard all partially captured bytes.

Verification
REQ-035 Mem 0600:A9 42, accept at once -> valid 2 cycles after OPC, am 1, imm 42, pc 0602.
REQ-036 0600:BD FF 12, X=01 -> am 6, eff_addr 1300, page_cross 1, pc 0603, latency 3.
REQ-037 0600:B1 FF, [00FF]=34, [0000]=12, Y=10, ZP_WRAP=1 -> am 9, eff_addr 1244, page_cross 0, latency 4.
REQ-038 0600:B5 F0, X=20 -> eff_addr 0010 (ZP_WRAP=1) / 0110 (ZP_WRAP=0).
REQ-039 instr_accept held low 5 cycles -> outputs stable, mem_rd 0; pc_load=1, pc_load_val=8000 with accept -> next OPC reads 8000.
REQ-040 reset_n low during PLO -> outputs zero asynchronously, pc 0600, refetch from 0600 after release.
